// File: rtl/inst_cache_assoc_if.sv
// Fetch-side and memory-fill-side signals of the instruction cache.
// The cache takes the slave view; the CPU/memory environment takes the master view.
interface inst_cache_assoc_if #(
    parameter int LINE_BITS = 256
);
    logic [31:0]          inst_addr_i;
    logic [31:0]          inst_data_o;
    logic                 inst_valid_o;
    logic                 mem_fc;
    logic                 hw_page_fault_o;
    logic [31:0]          addr_o;
    logic [LINE_BITS-1:0] data_i;
    logic                 rd_o;
    logic                 ack_i;
    logic                 hw_page_fault_i;
    logic [31:0]          miss_count_o;
    logic [31:0]          fault_count_o;

    modport slave (
        input  inst_addr_i, mem_fc, data_i, ack_i, hw_page_fault_i,
        output inst_data_o, inst_valid_o, hw_page_fault_o, addr_o, rd_o,
               miss_count_o, fault_count_o
    );

    modport master (
        output inst_addr_i, mem_fc, data_i, ack_i, hw_page_fault_i,
        input  inst_data_o, inst_valid_o, hw_page_fault_o, addr_o, rd_o,
               miss_count_o, fault_count_o
    );
endinterface

// File: rtl/inst_cache_assoc.sv
// Set-associative (1 or 2 way) instruction cache with combinational hits and LRU line fill.
// Define INST_CACHE_ASSOC_COUNTERS_EN to build the saturating miss/fault counters.
module inst_cache_assoc #(
    parameter int LINE_BITS = 256,
    parameter int SETS      = 64,
    parameter int WAYS      = 2
) (
    input  logic               clk,
    input  logic               rst,
    inst_cache_assoc_if.slave  bus
);
    localparam int OFF  = $clog2(LINE_BITS / 8);
    localparam int IDX  = $clog2(SETS);
    localparam int TAG  = 32 - OFF - IDX;
    localparam int WSEL = OFF - 2;

    typedef enum logic {S_IDLE, S_FILL} state_t;

    state_t                      state_q, state_d;
    logic [31:0]                 addr_q, addr_d;
    logic                        rd_q, rd_d;
    logic                        kill_q, kill_d;
    logic [WAYS-1:0][SETS-1:0]   valid_q, valid_d;

    logic [LINE_BITS-1:0] data_mem [WAYS][SETS];
    logic [TAG-1:0]       tag_mem  [WAYS][SETS];

    logic                 fill_ack;
    logic [IDX-1:0]       arr_idx;
    logic [TAG-1:0]       fetch_tag;
    logic [WSEL-1:0]      word_sel;
    logic [WAYS-1:0]      way_hit;
    logic [LINE_BITS-1:0] way_line [WAYS];
    logic [LINE_BITS-1:0] hit_line;
    logic                 hit;
    logic                 hit_way;
    logic                 lru_way;
    logic                 victim;
    logic                 unused_addr_bits;

    assign fill_ack  = (state_q == S_FILL) && bus.ack_i;
    // The fill write borrows the read index, so during the ack cycle the arrays look at the fill set.
    assign arr_idx   = fill_ack ? addr_q[OFF +: IDX] : bus.inst_addr_i[OFF +: IDX];
    assign fetch_tag = bus.inst_addr_i[31 -: TAG];
    assign word_sel  = bus.inst_addr_i[OFF-1:2];
    assign unused_addr_bits = ^bus.inst_addr_i[1:0];

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
            assign way_hit[gi]  = valid_q[gi][arr_idx] && (tag_mem[gi][arr_idx] == fetch_tag);
            assign way_line[gi] = data_mem[gi][arr_idx];
        end
    endgenerate

    always_comb begin
        hit_line = '0;
        hit_way  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_hit[w]) begin
                hit_line = way_line[w];
                hit_way  = 1'(w);
            end
        end
    end

    assign hit              = |way_hit;
    assign bus.inst_valid_o = hit;
    assign bus.inst_data_o  = hit_line[{word_sel, 5'd0} +: 32];

    // Lowest-index invalid way wins; otherwise replace the least-recently-used way.
    always_comb begin
        victim = lru_way;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[w][arr_idx]) begin
                victim = 1'(w);
            end
        end
    end

    generate
        if (WAYS == 2) begin : g_lru
            logic [SETS-1:0] lru_q, lru_d;

            always_comb begin
                lru_d = lru_q;
                if (fill_ack) begin
                    lru_d[arr_idx] = ~victim;
                end else if ((state_q == S_IDLE) && hit) begin
                    lru_d[arr_idx] = ~hit_way;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    lru_q <= '0;
                end else begin
                    lru_q <= lru_d;
                end
            end

            assign lru_way = lru_q[arr_idx];
        end else begin : g_no_lru
            assign lru_way = 1'b0;
        end
    endgenerate

    always_comb begin
        valid_d = valid_q;
        if (fill_ack) begin
            valid_d[victim][arr_idx] = ~bus.hw_page_fault_i & ~(kill_q | bus.mem_fc);
        end
        if (bus.mem_fc) begin
            valid_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        kill_d  = kill_q;
        case (state_q)
            S_IDLE: begin
                if (!hit && !bus.mem_fc) begin
                    state_d = S_FILL;
                    addr_d  = {bus.inst_addr_i[31:OFF], {OFF{1'b0}}};
                    rd_d    = 1'b1;
                end
            end
            S_FILL: begin
                if (bus.ack_i) begin
                    state_d = S_IDLE;
                    addr_d  = '0;
                    rd_d    = 1'b0;
                    kill_d  = 1'b0;
                end else begin
                    kill_d = kill_q | bus.mem_fc;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            kill_q  <= 1'b0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            kill_q  <= kill_d;
            valid_q <= valid_d;
        end
    end

    // Killed or faulting fills still write data/tag; only the valid bit keeps them invisible.
    always_ff @(posedge clk) begin
        if (fill_ack && !rst) begin
            data_mem[victim][arr_idx] <= bus.data_i;
            tag_mem[victim][arr_idx]  <= addr_q[31 -: TAG];
        end
    end

    assign bus.addr_o          = addr_q;
    assign bus.rd_o            = rd_q;
    assign bus.hw_page_fault_o = fill_ack & bus.hw_page_fault_i;

`ifdef INST_CACHE_ASSOC_COUNTERS_EN
    logic        miss_inc, fault_inc;
    logic [31:0] miss_count_q, miss_count_d;
    logic [31:0] fault_count_q, fault_count_d;

    assign miss_inc  = (state_q == S_IDLE) && (state_d == S_FILL);
    assign fault_inc = fill_ack & bus.hw_page_fault_i;

    always_comb begin
        miss_count_d  = miss_count_q;
        fault_count_d = fault_count_q;
        if (miss_inc && (miss_count_q != 32'hFFFF_FFFF)) begin
            miss_count_d = miss_count_q + 32'd1;
        end
        if (fault_inc && (fault_count_q != 32'hFFFF_FFFF)) begin
            fault_count_d = fault_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            miss_count_q  <= '0;
            fault_count_q <= '0;
        end else begin
            miss_count_q  <= miss_count_d;
            fault_count_q <= fault_count_d;
        end
    end

    assign bus.miss_count_o  = miss_count_q;
    assign bus.fault_count_o = fault_count_q;
`else
    assign bus.miss_count_o  = 32'h0;
    assign bus.fault_count_o = 32'h0;
`endif
endmodule

// File: tb/tb_inst_cache_assoc.sv
// Directed plus randomized bench for inst_cache_assoc against a recency-list cache model.
module tb_inst_cache_assoc;
    localparam int LB    = 256;
    localparam int SETS  = 64;
    localparam int WAYS  = 2;
    localparam int OFF   = 5;
    localparam int WORDS = LB / 32;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    inst_cache_assoc_if #(.LINE_BITS(LB)) bus ();

    inst_cache_assoc #(.LINE_BITS(LB), .SETS(SETS), .WAYS(WAYS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: per set, resident lines ordered most-recent first.
    logic [31:0] m_line [SETS][WAYS];
    logic [LB-1:0] m_data [SETS][WAYS];
    int m_cnt [SETS];
    int m_miss;
    int m_fault_n;

    function automatic int m_find(input int s, input logic [31:0] l);
        for (int i = 0; i < m_cnt[s]; i++) begin
            if (m_line[s][i] == l) return i;
        end
        return -1;
    endfunction

    task automatic m_touch(input int s, input int pos);
        logic [31:0] tl;
        logic [LB-1:0] td;
        tl = m_line[s][pos];
        td = m_data[s][pos];
        for (int i = pos; i > 0; i--) begin
            m_line[s][i] = m_line[s][i-1];
            m_data[s][i] = m_data[s][i-1];
        end
        m_line[s][0] = tl;
        m_data[s][0] = td;
    endtask

    task automatic m_insert(input int s, input logic [31:0] l, input logic [LB-1:0] d);
        if (m_cnt[s] < WAYS) m_cnt[s] = m_cnt[s] + 1;
        for (int i = m_cnt[s] - 1; i > 0; i--) begin
            m_line[s][i] = m_line[s][i-1];
            m_data[s][i] = m_data[s][i-1];
        end
        m_line[s][0] = l;
        m_data[s][0] = d;
    endtask

    // A faulting fill overwrites the victim and leaves it invalid: a full set loses its LRU line.
    task automatic m_fault(input int s);
        if (m_cnt[s] == WAYS) m_cnt[s] = m_cnt[s] - 1;
    endtask

    task automatic m_flush();
        for (int i = 0; i < SETS; i++) m_cnt[i] = 0;
    endtask

    function automatic logic [LB-1:0] rand_line();
        logic [LB-1:0] r;
        for (int i = 0; i < WORDS; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_counters();
`ifdef INST_CACHE_ASSOC_COUNTERS_EN
        check("miss_count", bus.miss_count_o, 32'(m_miss));
        check("fault_count", bus.fault_count_o, 32'(m_fault_n));
`else
        check("miss_count_off", bus.miss_count_o, 32'h0);
        check("fault_count_off", bus.fault_count_o, 32'h0);
`endif
    endtask

    // Called at posedge+1 in IDLE; returns at posedge+1 in IDLE with the line resident or given up.
    task automatic fetch(input logic [31:0] a, input int lat, input bit fault, input int flush_at,
                         input logic [LB-1:0] d, input int want_hit);
        logic [31:0] l;
        int s, w, pos, cur_lat, cur_flush, attempts;
        bit cur_fault, flushed, done;
        l = {a[31:OFF], 5'b0};
        s = int'(a[OFF +: 6]);
        w = int'(a[OFF-1:2]);
        bus.inst_addr_i = a;
        @(negedge clk);
        pos = m_find(s, l);
        check1("rd_idle", bus.rd_o, 1'b0);
        if (want_hit >= 0) check1("want_hit", bus.inst_valid_o, want_hit != 0);
        check1("hit", bus.inst_valid_o, pos >= 0);
        $display("fetch %h lat=%0d fault=%0d flush_at=%0d model_hit=%0d", a, lat, fault, flush_at, pos >= 0);
        if (pos >= 0) begin
            check("hit_data", bus.inst_data_o, m_data[s][pos][w*32 +: 32]);
            m_touch(s, pos);
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        m_miss++;
        cur_lat = lat; cur_fault = fault; cur_flush = flush_at;
        done = 1'b0; attempts = 0;
        while (!done) begin
            flushed = 1'b0;
            attempts++;
            for (int i = 0; i <= cur_lat; i++) begin
                if (i == cur_lat) begin
                    bus.ack_i = 1'b1;
                    bus.data_i = d;
                    bus.hw_page_fault_i = cur_fault;
                end
                bus.mem_fc = (i == cur_flush);
                @(negedge clk);
                check1("rd_fill", bus.rd_o, 1'b1);
                check("addr_fill", bus.addr_o, l);
                check1("pf_out", bus.hw_page_fault_o, (i == cur_lat) && cur_fault);
                if (i == cur_lat) check_counters();
                @(posedge clk); #1;
                if (bus.mem_fc) begin
                    flushed = 1'b1;
                    m_flush();
                end
                bus.mem_fc = 1'b0;
            end
            bus.ack_i = 1'b0;
            bus.hw_page_fault_i = 1'b0;
            if (cur_fault) begin
                m_fault_n++;
                m_fault(s);
            end else if (!flushed) begin
                m_insert(s, l, d);
            end
            @(negedge clk);
            check1("rd_gap", bus.rd_o, 1'b0);
            check("addr_gap", bus.addr_o, 32'h0);
            pos = m_find(s, l);
            check1("post_fill_hit", bus.inst_valid_o, pos >= 0);
            if (pos >= 0) begin
                check("post_fill_data", bus.inst_data_o, m_data[s][pos][w*32 +: 32]);
                done = 1'b1;
            end
            @(posedge clk); #1;
            if (!done) begin
                m_miss++;
                cur_lat = $urandom_range(0, 2);
                cur_fault = 1'b0;
                cur_flush = -1;
                vectors++;
                assert (attempts < 4) else begin
                    miscompares++;
                    $error("FAIL refill_bound: observed %0d attempts expected under 4", attempts);
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic flush_idle(input logic [31:0] a);
        int pos;
        bus.inst_addr_i = a;
        bus.mem_fc = 1'b1;
        @(negedge clk);
        pos = m_find(int'(a[OFF +: 6]), {a[31:OFF], 5'b0});
        check1("flush_hit", bus.inst_valid_o, pos >= 0);
        check1("flush_rd", bus.rd_o, 1'b0);
        $display("flush in idle at %h", a);
        @(posedge clk); #1;
        bus.mem_fc = 1'b0;
        m_flush();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LB-1:0] d;
        logic [31:0] a;
        int lat;
        vectors = 0;
        miscompares = 0;
        m_miss = 0;
        m_fault_n = 0;
        m_flush();
        rst = 1'b1;
        bus.inst_addr_i = 32'h0;
        bus.mem_fc = 1'b0;
        bus.data_i = '0;
        bus.ack_i = 1'b0;
        bus.hw_page_fault_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check1("rst_rd", bus.rd_o, 1'b0);
        check("rst_addr", bus.addr_o, 32'h0);
        check1("rst_valid", bus.inst_valid_o, 1'b0);
        check1("rst_pf", bus.hw_page_fault_o, 1'b0);
        check_counters();
        @(posedge clk); #1;
        rst = 1'b0;

        // First fill: word 1 of line 0x100.
        d = rand_line();
        d[63:32] = 32'hDEAD_BEEF;
        fetch(32'h0000_0104, 0, 1'b0, -1, d, 0);
        @(negedge clk);
        check1("t1_valid", bus.inst_valid_o, 1'b1);
        check("t1_word", bus.inst_data_o, 32'hDEAD_BEEF);
        @(posedge clk); #1;

        // LRU eviction in set 0.
        fetch(32'h0000_0000, 1, 1'b0, -1, rand_line(), 0);
        fetch(32'h0000_0800, 0, 1'b0, -1, rand_line(), 0);
        fetch(32'h0000_0000, 0, 1'b0, -1, rand_line(), 1);
        fetch(32'h0000_1000, 2, 1'b0, -1, rand_line(), 0);
        fetch(32'h0000_0004, 0, 1'b0, -1, rand_line(), 1);
        fetch(32'h0000_0800, 0, 1'b0, -1, rand_line(), 0);

        // Faulting fill, then automatic re-request.
        fetch(32'h0000_2000, 0, 1'b1, -1, rand_line(), 0);

        // Flush during fill.
        fetch(32'h0000_3000, 2, 1'b0, 1, rand_line(), 0);
        fetch(32'h0000_0104, 0, 1'b0, -1, rand_line(), 0);
        check_counters();

        for (int n = 0; n < 300; n++) begin
            a = (32'($urandom_range(0, 3)) << 11) | (32'($urandom_range(0, 3)) << 5)
              | (32'($urandom_range(0, 7)) << 2);
            if ($urandom_range(0, 99) < 10) begin
                flush_idle(a);
            end else begin
                lat = $urandom_range(0, 3);
                fetch(a, lat, $urandom_range(0, 7) == 0,
                      ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, lat)) : -1,
                      rand_line(), -1);
            end
        end
        check_counters();

        // Reset during fill; the late ack must be ignored.
        bus.inst_addr_i = 32'h0000_4000;
        @(negedge clk);
        check1("rstf_pre_miss", bus.inst_valid_o, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check1("rstf_rd", bus.rd_o, 1'b1);
        $display("reset asserted during fill of 00004000");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_flush();
        m_miss = 0;
        m_fault_n = 0;
        d = rand_line();
        bus.ack_i = 1'b1;
        bus.data_i = d;
        @(negedge clk);
        check1("rstf_rd_low", bus.rd_o, 1'b0);
        check("rstf_addr", bus.addr_o, 32'h0);
        check1("rstf_no_hit", bus.inst_valid_o, 1'b0);
        check_counters();
        @(posedge clk); #1;
        bus.ack_i = 1'b0;
        m_miss = 1;
        @(negedge clk);
        check1("rstf_no_install", bus.inst_valid_o, 1'b0);
        check1("rstf_reissue", bus.rd_o, 1'b1);
        @(posedge clk); #1;
        bus.ack_i = 1'b1;
        @(posedge clk); #1;
        bus.ack_i = 1'b0;
        m_insert(0, 32'h0000_4000, d);
        fetch(32'h0000_4000, 0, 1'b0, -1, rand_line(), 1);
        check_counters();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
